otter_cu_fsm_gen: RTL and testbench

OTTER_CU_FSM_GEN -- requirements
Module: otter_cu_fsm_gen

---
 rtl/otter_cu_pkg.sv | 54 +++++
 rtl/otter_irq_arbiter.sv | 58 +++++
 rtl/otter_cu_fsm_gen.sv | 201 ++++++++++++++++++++
 tb/tb_otter_cu_fsm_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// Shared definitions for the OTTER control-unit FSM.
// Holds the opcode and SYSTEM funct3 encodings, the FSM state encoding,
// the trap-cause codes, the MRET func12 value and a width helper used
// to size the interrupt-id buses.
package otter_cu_pkg;

    // RV32I major opcodes seen by the control unit
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_t;

    // funct3 values under the SYSTEM opcode; PRIV covers ECALL/EBREAK/MRET
    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_system_t;

    // FETCH is encoded as zero so a cleared register lands in FETCH
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXECUTE = 3'd1,
        ST_WB      = 3'd2,
        ST_INTER   = 3'd3,
        ST_TRAP    = 3'd4
    } state_t;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_FETCH = 2'b01;
    localparam logic [1:0] TRAP_LOAD  = 2'b10;
    localparam logic [1:0] TRAP_STORE = 2'b11;

    localparam logic [11:0] FUNC12_MRET = 12'h302;

    // Width of a channel index; a single channel still needs one bit
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otter_irq_arbiter.sv
// Interrupt pending register and fixed-priority selector.
// Ports:
//   CU_CLK, CU_RESET   clock and synchronous active-high reset
//   irq                level requests; each high bit sets its pending bit
//   irq_en             per-channel enable mask
//   clr, clr_id        clear the pending bit of channel clr_id this cycle
//   any                some enabled channel is pending (combinational)
//   sel_id             lowest-index enabled pending channel (combinational)
module otter_irq_arbiter
    import otter_cu_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic                             CU_CLK,
    input  logic                             CU_RESET,
    input  logic [NUM_IRQ-1:0]               irq,
    input  logic [NUM_IRQ-1:0]               irq_en,
    input  logic                             clr,
    input  logic [id_width(NUM_IRQ)-1:0]     clr_id,
    output logic                             any,
    output logic [id_width(NUM_IRQ)-1:0]     sel_id
);

    localparam int unsigned ID_W = id_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] req;

    // Clear is applied before the set, so a request in the clear cycle survives
    always_comb begin
        clr_mask  = clr ? (NUM_IRQ'(1) << clr_id) : '0;
        pending_d = (pending_q & ~clr_mask) | irq;
    end

    // A request raised this cycle already counts as pending for selection
    always_comb begin
        req    = (pending_q | irq) & irq_en;
        any    = |req;
        sel_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // Pending register
    always_ff @(posedge CU_CLK) begin
        if (CU_RESET) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/otter_cu_fsm_gen.sv
// OTTER multicycle control-unit FSM with interrupts and bus-timeout traps.
// Ports:
//   CU_CLK, CU_RESET              clock, synchronous active-high reset
//   CU_OPCODE/FUNC3/FUNC12        fields of the current instruction
//   MEM_VALID1, MEM_VALID2        fetch done / data access done
//   CU_IRQ, CU_IRQ_EN, CU_MIE     interrupt requests, channel mask, global enable
//   CU_PCWRITE .. CU_trapTaken    per-cycle control strobes (decoded from state)
//   CU_INT_ID                     channel being serviced, registered on INTER entry
//   CU_trapCause                  01 fetch, 10 load, 11 store timeout; held until next trap
module otter_cu_fsm_gen
    import otter_cu_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                          CU_CLK,
    input  logic                          CU_RESET,
    input  logic [6:0]                    CU_OPCODE,
    input  logic [2:0]                    CU_FUNC3,
    input  logic [11:0]                   CU_FUNC12,
    input  logic                          MEM_VALID1,
    input  logic                          MEM_VALID2,
    input  logic [NUM_IRQ-1:0]            CU_IRQ,
    input  logic [NUM_IRQ-1:0]            CU_IRQ_EN,
    input  logic                          CU_MIE,
    output logic                          CU_PCWRITE,
    output logic                          CU_REGWRITE,
    output logic                          CU_MEMWRITE,
    output logic                          CU_MEMREAD1,
    output logic                          CU_MEMREAD2,
    output logic                          CU_csrWrite,
    output logic                          CU_intTaken,
    output logic                          CU_trapTaken,
    output logic [id_width(NUM_IRQ)-1:0]  CU_INT_ID,
    output logic [1:0]                    CU_trapCause
);

    localparam int unsigned ID_W  = id_width(NUM_IRQ);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state_q;
    state_t            state_d;
    state_t            resume_state;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;
    logic [ID_W-1:0]   int_id_d;
    logic [1:0]        cause_d;
    logic [1:0]        wait_cause;
    logic              waiting;
    logic              irq_any;
    logic              irq_eligible;
    logic [ID_W-1:0]   irq_sel;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_system;
    logic              is_mret;

    // Instruction decode
    assign is_load      = (CU_OPCODE == OPC_LOAD);
    assign is_store     = (CU_OPCODE == OPC_STORE);
    assign is_branch    = (CU_OPCODE == OPC_BRANCH);
    assign is_system    = (CU_OPCODE == OPC_SYSTEM);
    assign is_mret      = is_system && (CU_FUNC3 == F3_PRIV) && (CU_FUNC12 == FUNC12_MRET);

    assign irq_eligible = CU_MIE && irq_any;
    assign resume_state = irq_eligible ? ST_INTER : ST_FETCH;

    otter_irq_arbiter #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_arbiter (
        .CU_CLK   (CU_CLK),
        .CU_RESET (CU_RESET),
        .irq      (CU_IRQ),
        .irq_en   (CU_IRQ_EN),
        .clr      (state_q == ST_INTER),
        .clr_id   (CU_INT_ID),
        .any      (irq_any),
        .sel_id   (irq_sel)
    );

    // State, wait counter, interrupt id and trap cause registers
    always_ff @(posedge CU_CLK) begin
        if (CU_RESET) begin
            state_q      <= ST_FETCH;
            wait_cnt_q   <= '0;
            CU_INT_ID    <= '0;
            CU_trapCause <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            CU_INT_ID    <= int_id_d;
            CU_trapCause <= cause_d;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        int_id_d     = CU_INT_ID;
        cause_d      = CU_trapCause;
        waiting      = 1'b0;
        wait_cause   = TRAP_FETCH;
        CU_PCWRITE   = 1'b0;
        CU_REGWRITE  = 1'b0;
        CU_MEMWRITE  = 1'b0;
        CU_MEMREAD1  = 1'b0;
        CU_MEMREAD2  = 1'b0;
        CU_csrWrite  = 1'b0;
        CU_intTaken  = 1'b0;
        CU_trapTaken = 1'b0;

        case (state_q)
            ST_FETCH: begin
                CU_MEMREAD1 = 1'b1;
                wait_cause  = TRAP_FETCH;
                if (MEM_VALID1) begin
                    state_d = ST_EXECUTE;
                end else begin
                    waiting = 1'b1;
                end
            end

            ST_EXECUTE: begin
                if (is_load) begin
                    CU_MEMREAD2 = 1'b1;
                    wait_cause  = TRAP_LOAD;
                    if (MEM_VALID2) begin
                        state_d = ST_WB;
                    end else begin
                        waiting = 1'b1;
                    end
                end else if (is_store) begin
                    CU_MEMWRITE = 1'b1;
                    wait_cause  = TRAP_STORE;
                    if (MEM_VALID2) begin
                        CU_PCWRITE = 1'b1;
                        state_d    = resume_state;
                    end else begin
                        waiting = 1'b1;
                    end
                end else begin
                    CU_PCWRITE  = 1'b1;
                    CU_REGWRITE = !(is_branch || is_mret);
                    CU_csrWrite = is_system && (CU_FUNC3 != F3_PRIV);
                    state_d     = resume_state;
                end
            end

            ST_WB: begin
                CU_REGWRITE = 1'b1;
                CU_PCWRITE  = 1'b1;
                state_d     = resume_state;
            end

            ST_INTER: begin
                CU_intTaken = 1'b1;
                CU_PCWRITE  = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_TRAP: begin
                CU_trapTaken = 1'b1;
                CU_PCWRITE   = 1'b1;
                state_d      = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Timeout is judged only when valid is still low, so a late valid wins
        if (waiting) begin
            if ((MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
                state_d = ST_TRAP;
                cause_d = wait_cause;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end

        if (state_d == ST_INTER && state_q != ST_INTER) begin
            int_id_d = irq_sel;
        end

        // While reset is held the strobes look like a quiet FETCH
        if (CU_RESET) begin
            CU_PCWRITE   = 1'b0;
            CU_REGWRITE  = 1'b0;
            CU_MEMWRITE  = 1'b0;
            CU_MEMREAD1  = 1'b1;
            CU_MEMREAD2  = 1'b0;
            CU_csrWrite  = 1'b0;
            CU_intTaken  = 1'b0;
            CU_trapTaken = 1'b0;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm_gen.sv
// Self-checking bench for otter_cu_fsm_gen: directed scenarios followed by
// randomized instructions, checked per cycle against a transaction-level model.
module tb_otter_cu_fsm_gen;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    // Strobe bit positions in the packed observation vector
    localparam logic [7:0] S_PC  = 8'h80;
    localparam logic [7:0] S_RW  = 8'h40;
    localparam logic [7:0] S_MW  = 8'h20;
    localparam logic [7:0] S_MR1 = 8'h10;
    localparam logic [7:0] S_MR2 = 8'h08;
    localparam logic [7:0] S_CSR = 8'h04;
    localparam logic [7:0] S_INT = 8'h02;
    localparam logic [7:0] S_TRP = 8'h01;

    logic        CU_CLK = 1'b0;
    logic        CU_RESET;
    logic [6:0]  CU_OPCODE;
    logic [2:0]  CU_FUNC3;
    logic [11:0] CU_FUNC12;
    logic        MEM_VALID1;
    logic        MEM_VALID2;
    logic [3:0]  CU_IRQ;
    logic [3:0]  CU_IRQ_EN;
    logic        CU_MIE;
    logic        CU_PCWRITE;
    logic        CU_REGWRITE;
    logic        CU_MEMWRITE;
    logic        CU_MEMREAD1;
    logic        CU_MEMREAD2;
    logic        CU_csrWrite;
    logic        CU_intTaken;
    logic        CU_trapTaken;
    logic [1:0]  CU_INT_ID;
    logic [1:0]  CU_trapCause;

    logic [7:0]  strb;
    logic [3:0]  pend;
    int          errors = 0;
    int          checks = 0;

    logic [6:0]  opc_tab [9] = '{OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH,
                                  OP_SYSTEM, OP_JAL, OP_LUI, OP_AUIPC};

    assign strb = {CU_PCWRITE, CU_REGWRITE, CU_MEMWRITE, CU_MEMREAD1,
                   CU_MEMREAD2, CU_csrWrite, CU_intTaken, CU_trapTaken};

    always #5 CU_CLK = ~CU_CLK;

    otter_cu_fsm_gen #(
        .NUM_IRQ     (4),
        .MEM_TIMEOUT (16)
    ) dut (
        .CU_CLK       (CU_CLK),
        .CU_RESET     (CU_RESET),
        .CU_OPCODE    (CU_OPCODE),
        .CU_FUNC3     (CU_FUNC3),
        .CU_FUNC12    (CU_FUNC12),
        .MEM_VALID1   (MEM_VALID1),
        .MEM_VALID2   (MEM_VALID2),
        .CU_IRQ       (CU_IRQ),
        .CU_IRQ_EN    (CU_IRQ_EN),
        .CU_MIE       (CU_MIE),
        .CU_PCWRITE   (CU_PCWRITE),
        .CU_REGWRITE  (CU_REGWRITE),
        .CU_MEMWRITE  (CU_MEMWRITE),
        .CU_MEMREAD1  (CU_MEMREAD1),
        .CU_MEMREAD2  (CU_MEMREAD2),
        .CU_csrWrite  (CU_csrWrite),
        .CU_intTaken  (CU_intTaken),
        .CU_trapTaken (CU_trapTaken),
        .CU_INT_ID    (CU_INT_ID),
        .CU_trapCause (CU_trapCause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check strobes mid-cycle, advance
    task automatic cyc(input logic v1, input logic v2, input logic [3:0] irq,
                       input logic [7:0] exp, input string tag);
        MEM_VALID1 = v1;
        MEM_VALID2 = v2;
        CU_IRQ     = irq;
        pend       = pend | irq;
        @(negedge CU_CLK);
        chk(tag, 32'(strb), 32'(exp));
        @(posedge CU_CLK);
        #1;
    endtask

    // Interrupt service if the model says one is due; irq_int is driven during INTER
    task automatic maybe_inter(input logic [3:0] irq_int);
        logic [3:0] req;
        int lowest;
        req    = pend & CU_IRQ_EN;
        lowest = -1;
        if (CU_MIE && (req != 4'b0)) begin
            for (int b = 0; b < 4; b++) begin
                if (req[b] && lowest < 0) lowest = b;
            end
            chk("int_id", 32'(CU_INT_ID), 32'(lowest));
            pend[lowest] = 1'b0;
            cyc(1'b0, 1'b0, irq_int, S_INT | S_PC, "inter");
        end
    endtask

    // Complete instruction with fw fetch waits and mw data waits
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] f12,
                             input int fw, input int mw,
                             input logic [3:0] irq_dec, input logic [3:0] irq_int);
        logic [7:0] e;
        CU_OPCODE = opc;
        CU_FUNC3  = f3;
        CU_FUNC12 = f12;
        for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, 4'b0, S_MR1, "fetch_wait");
        cyc(1'b1, 1'b0, 4'b0, S_MR1, "fetch_done");
        if (opc == OP_LOAD) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, 4'b0, S_MR2, "load_wait");
            cyc(1'b0, 1'b1, 4'b0, S_MR2, "load_done");
            cyc(1'b0, 1'b0, irq_dec, S_RW | S_PC, "writeback");
        end else if (opc == OP_STORE) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, 4'b0, S_MW, "store_wait");
            cyc(1'b0, 1'b1, irq_dec, S_MW | S_PC, "store_done");
        end else begin
            e = S_PC;
            if (!(opc == OP_BRANCH || (opc == OP_SYSTEM && f3 == 3'd0 && f12 == 12'h302)))
                e = e | S_RW;
            if (opc == OP_SYSTEM && f3 != 3'd0)
                e = e | S_CSR;
            cyc(1'b0, 1'b0, irq_dec, e, "execute");
        end
        maybe_inter(irq_int);
    endtask

    // Access that never completes: kind 0 fetch, 1 load, 2 store
    task automatic run_timeout(input int kind, input logic [3:0] irq_first);
        logic [7:0] e;
        logic [1:0] cause;
        CU_FUNC3  = 3'd0;
        CU_FUNC12 = 12'h0;
        CU_OPCODE = (kind == 1) ? OP_LOAD : (kind == 2) ? OP_STORE : OP_OP;
        e     = (kind == 0) ? S_MR1 : (kind == 1) ? S_MR2 : S_MW;
        cause = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b10 : 2'b11;
        if (kind != 0) cyc(1'b1, 1'b0, 4'b0, S_MR1, "fetch_done");
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, (i == 0) ? irq_first : 4'b0, e, "timeout_wait");
        chk("trap_cause", 32'(CU_trapCause), 32'(cause));
        cyc(1'b0, 1'b0, 4'b0, S_TRP | S_PC, "trap");
        cyc(1'b0, 1'b0, 4'b0, S_MR1, "after_trap");
    endtask

    initial begin
        CU_RESET   = 1'b1;
        CU_OPCODE  = OP_OP;
        CU_FUNC3   = 3'd0;
        CU_FUNC12  = 12'h0;
        MEM_VALID1 = 1'b0;
        MEM_VALID2 = 1'b0;
        CU_IRQ     = 4'b0;
        CU_IRQ_EN  = 4'b0;
        CU_MIE     = 1'b0;
        pend       = 4'b0;
        @(posedge CU_CLK);
        #1;
        cyc(1'b0, 1'b0, 4'b0, S_MR1, "in_reset");
        cyc(1'b0, 1'b0, 4'b0, S_MR1, "in_reset");
        CU_RESET = 1'b0;
        chk("reset_int_id", 32'(CU_INT_ID), 32'd0);
        chk("reset_cause", 32'(CU_trapCause), 32'd0);

        // ADD, LOAD with three waits, STORE, then PC/REG/CSR decode cases
        run_instr(OP_OP,     3'd0, 12'h000, 1, 0, 4'b0, 4'b0);
        run_instr(OP_LOAD,   3'd2, 12'h000, 0, 3, 4'b0, 4'b0);
        run_instr(OP_STORE,  3'd2, 12'h000, 2, 4, 4'b0, 4'b0);
        run_instr(OP_BRANCH, 3'd0, 12'h000, 0, 0, 4'b0, 4'b0);
        run_instr(OP_SYSTEM, 3'd0, 12'h302, 0, 0, 4'b0, 4'b0);
        run_instr(OP_SYSTEM, 3'd0, 12'h000, 0, 0, 4'b0, 4'b0);
        run_instr(OP_SYSTEM, 3'd1, 12'h300, 0, 0, 4'b0, 4'b0);
        run_instr(OP_SYSTEM, 3'd6, 12'h302, 0, 0, 4'b0, 4'b0);

        // Two requests at once are serviced lowest first
        CU_IRQ_EN = 4'b1111;
        CU_MIE    = 1'b1;
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b1010, 4'b0);
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0000, 4'b0);
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0000, 4'b0);

        // Request held through INTER re-arms the channel being cleared
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0001, 4'b0001);
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0000, 4'b0);
        run_instr(OP_LOAD, 3'd0, 12'h0, 0, 1, 4'b0100, 4'b0);

        // Masked channels stay pending, global disable blocks service
        CU_IRQ_EN = 4'b0001;
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b1000, 4'b0);
        CU_MIE = 1'b0;
        CU_IRQ_EN = 4'b1111;
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0000, 4'b0);
        CU_MIE = 1'b1;
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0000, 4'b0);

        // Timeouts; no interrupt is taken out of TRAP
        run_timeout(0, 4'b0);
        run_timeout(1, 4'b0);
        run_timeout(2, 4'b0100);

        // Reset in the middle of a load drops pending and clears registers
        CU_MIE    = 1'b0;
        CU_OPCODE = OP_LOAD;
        cyc(1'b1, 1'b0, 4'b0, S_MR1, "fetch_done");
        cyc(1'b0, 1'b0, 4'b0010, S_MR2, "load_wait");
        cyc(1'b0, 1'b0, 4'b0, S_MR2, "load_wait");
        CU_RESET = 1'b1;
        pend     = 4'b0;
        cyc(1'b0, 1'b0, 4'b0, S_MR1, "reset_mid_load");
        CU_RESET = 1'b0;
        chk("rst_int_id", 32'(CU_INT_ID), 32'd0);
        chk("rst_cause", 32'(CU_trapCause), 32'd0);
        CU_MIE = 1'b1;
        run_instr(OP_OP, 3'd0, 12'h0, 0, 0, 4'b0, 4'b0);

        // Valid on the last permitted wait cycle completes normally
        run_instr(OP_LOAD,  3'd0, 12'h0, 15, 15, 4'b0, 4'b0);
        run_instr(OP_STORE, 3'd0, 12'h0, 15, 15, 4'b0, 4'b0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [6:0]  opc;
            logic [11:0] f12;
            logic [3:0]  irq_d;
            logic [3:0]  irq_i;
            opc   = opc_tab[$urandom_range(0, 8)];
            f12   = ($urandom_range(0, 1) == 0) ? 12'h302 : 12'($urandom);
            irq_d = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            irq_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            CU_IRQ_EN = 4'($urandom);
            CU_MIE    = ($urandom_range(0, 3) != 0);
            run_instr(opc, 3'($urandom), f12, $urandom_range(0, 15), $urandom_range(0, 15),
                      irq_d, irq_i);
        end

        cyc(1'b0, 1'b0, 4'b0, S_MR1, "final_fetch");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
